// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR with auto/manual stepping and a registered
// active-low seven-segment hex display driver.
module lfsr_hex_display #(
    parameter int               WIDTH    = 8,
    parameter int               DIGITS   = WIDTH / 4,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'('h1D),
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1),
    parameter int               DIV      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  auto,
    input  logic                  step,
    input  logic                  freeze,
    input  logic                  load,
    input  logic [WIDTH-1:0]      seed,
    input  logic [DIGITS-1:0]     blank,
    output logic [WIDTH-1:0]      q,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                step_d_q, step_d_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;

    logic             step_rise;
    logic             run;
    logic             tick;
    logic             adv;
    logic             fb;
    logic [WIDTH-1:0] shifted;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        p = 7'h7F;
        case (v)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            4'hF: p = 7'h0E;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // Advance request: prescaler tick in auto mode, step edge in manual mode.
    always_comb begin
        step_rise = step & ~step_d_q;
        run       = auto & ~freeze;
        tick      = run & (cnt_q == CNT_LAST);
        adv       = ~freeze & (tick | (~auto & step_rise));
        fb        = ^(lfsr_q & TAPS);
        shifted   = {fb, lfsr_q[WIDTH-1:1]};
    end

    // Next state: load beats advance; an all-zero state escapes to 1.
    always_comb begin
        step_d_d = step;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        if (load) begin
            lfsr_d = seed;
            cnt_d  = '0;
        end else begin
            if (adv) begin
                lfsr_d = (lfsr_q == '0) ? WIDTH'(1) : shifted;
            end
            if (run) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // Per-digit decode of the current state, with blanking.
    always_comb begin
        seg_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            seg_d[7*k +: 7] = blank[k] ? 7'h7F : hex7(lfsr_q[4*k +: 4]);
        end
    end

    // State registers; reset shows the seed with a dark display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q   <= SEED_RST;
            cnt_q    <= '0;
            step_d_q <= 1'b0;
            seg_q    <= '1;
        end else begin
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            step_d_q <= step_d_d;
            seg_q    <= seg_d;
        end
    end

    assign q   = lfsr_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Randomized and directed checks of lfsr_hex_display against a
// behavioural model, for an 8-bit/DIV=4 and a 16-bit/DIV=1 instance.
module tb_lfsr_hex_display;

    localparam int DIV8 = 4;

    logic clk = 1'b0;
    logic rst;

    logic        auto8, step8, freeze8, load8;
    logic [7:0]  seed8;
    logic [1:0]  blank8;
    logic [7:0]  q8;
    logic [13:0] seg8;

    logic        load16;
    logic [15:0] seed16;
    logic [3:0]  blank16;
    logic [15:0] q16;
    logic [27:0] seg16;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lfsr_hex_display #(
        .WIDTH(8), .TAPS(8'h1D), .SEED_RST(8'h01), .DIV(DIV8)
    ) dut8 (
        .clk(clk), .rst(rst), .auto(auto8), .step(step8),
        .freeze(freeze8), .load(load8), .seed(seed8),
        .blank(blank8), .q(q8), .seg(seg8)
    );

    lfsr_hex_display #(
        .WIDTH(16), .TAPS(16'hB400), .SEED_RST(16'h0001), .DIV(1)
    ) dut16 (
        .clk(clk), .rst(rst), .auto(1'b1), .step(1'b0),
        .freeze(1'b0), .load(load16), .seed(seed16),
        .blank(blank16), .q(q16), .seg(seg16)
    );

    function automatic logic [15:0] nxt(input logic [15:0] v,
                                        input logic [15:0] taps,
                                        input int w);
        int ones;
        if (v == 16'h0) return 16'h1;
        ones = $countones(v & taps);
        return (v >> 1) | (16'(ones % 2) << (w - 1));
    endfunction

    function automatic logic [27:0] seg_of(input logic [15:0] v,
                                           input logic [3:0] bl,
                                           input int digits);
        logic [6:0] tbl [16];
        logic [27:0] r;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        r = '1;
        for (int k = 0; k < digits; k++) begin
            r[7*k +: 7] = bl[k] ? 7'h7F : tbl[v[4*k +: 4]];
        end
        return r;
    endfunction

    logic [7:0]  m8_q;
    int          m8_cnt;
    logic        m8_prev;
    logic [27:0] m8_seg;
    logic [15:0] m16_q;
    logic [27:0] m16_seg;

    // Model of the 8-bit instance: cycle-count prescaler, edge on step.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m8_q    <= 8'h01;
            m8_cnt  <= 0;
            m8_prev <= 1'b0;
            m8_seg  <= '1;
        end else begin
            m8_seg  <= seg_of({8'h0, m8_q}, {2'b0, blank8}, 2);
            m8_prev <= step8;
            if (load8) begin
                m8_q   <= seed8;
                m8_cnt <= 0;
            end else begin
                if (!freeze8 && ((auto8 && m8_cnt == DIV8 - 1) ||
                                 (!auto8 && step8 && !m8_prev)))
                    m8_q <= 8'(nxt({8'h0, m8_q}, 16'h001D, 8));
                if (auto8 && !freeze8)
                    m8_cnt <= (m8_cnt + 1) % DIV8;
            end
        end
    end

    // Model of the 16-bit instance: always running with DIV = 1.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m16_q   <= 16'h0001;
            m16_seg <= '1;
        end else begin
            m16_seg <= seg_of(m16_q, blank16, 4);
            m16_q   <= load16 ? seed16 : nxt(m16_q, 16'hB400, 16);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against both models.
    always @(negedge clk) begin
        chk("q8_model", 32'(q8), 32'(m8_q));
        chk("seg8_model", 32'(seg8), 32'(m8_seg[13:0]));
        chk("q16_model", 32'(q16), 32'(m16_q));
        chk("seg16_model", 32'(seg16), 32'(m16_seg));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_step();
        step8 = 1'b1;
        cyc(1);
        step8 = 1'b0;
        cyc(1);
    endtask

    logic [7:0] exp_seq [5];

    initial begin
        exp_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        rst = 1'b0;
        auto8 = 1'b0; step8 = 1'b0; freeze8 = 1'b0; load8 = 1'b0;
        seed8 = 8'h00; blank8 = 2'b00;
        load16 = 1'b0; seed16 = 16'h0; blank16 = 4'h0;
        cyc(3);
        chk("reset_q", 32'(q8), 32'h01);
        chk("reset_seg", 32'(seg8), 32'h3FFF);
        chk("reset_seg16", 32'(seg16), 32'hFFFFFFF);
        rst = 1'b1;
        cyc(1);
        chk("first_decode", 32'(seg8), 32'h2079);
        chk("q16_first", 32'(q16), 32'h0000);
        cyc(1);
        chk("q16_escape", 32'(q16), 32'h0001);

        for (int i = 0; i < 5; i++) begin
            pulse_step();
            chk("manual_seq", 32'(q8), 32'(exp_seq[i]));
        end
        step8 = 1'b1;
        cyc(10);
        step8 = 1'b0;
        chk("step_held", 32'(q8), 32'hC4);

        cyc(1);
        auto8 = 1'b1;
        cyc(3);
        chk("auto_pre", 32'(q8), 32'hC4);
        cyc(1);
        chk("auto_edge4", 32'(q8), 32'hE2);
        cyc(2);
        freeze8 = 1'b1;
        cyc(6);
        chk("frozen", 32'(q8), 32'hE2);
        freeze8 = 1'b0;
        cyc(1);
        chk("unfreeze_1", 32'(q8), 32'hE2);
        cyc(1);
        chk("unfreeze_2", 32'(q8), 32'h71);

        cyc(3);
        load8 = 1'b1;
        seed8 = 8'hA5;
        cyc(1);
        load8 = 1'b0;
        chk("load_on_tick", 32'(q8), 32'hA5);
        cyc(1);
        chk("load_seg", 32'(seg8), 32'h0412);
        cyc(2);
        chk("cnt_cleared", 32'(q8), 32'hA5);
        cyc(1);
        chk("after_load_adv", 32'(q8), 32'h52);

        auto8 = 1'b0;
        load8 = 1'b1;
        seed8 = 8'h00;
        cyc(1);
        load8 = 1'b0;
        chk("zero_load", 32'(q8), 32'h00);
        pulse_step();
        chk("zero_escape", 32'(q8), 32'h01);

        load8 = 1'b1;
        seed8 = 8'h3C;
        blank8 = 2'b10;
        cyc(1);
        load8 = 1'b0;
        cyc(1);
        chk("blank_seg", 32'(seg8), 32'h3FC6);

        auto8 = 1'b1;
        cyc(2);
        rst = 1'b0;
        #1;
        chk("midop_reset_q", 32'(q8), 32'h01);
        chk("midop_reset_seg", 32'(seg8), 32'h3FFF);
        cyc(2);
        rst = 1'b1;
        blank8 = 2'b00;

        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            step8   = 1'($urandom % 2);
            freeze8 = ($urandom % 10) == 0;
            load8   = ($urandom % 25) == 0;
            seed8   = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
            blank8  = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
            if (($urandom % 40) == 0) auto8 = ~auto8;
            load16  = ($urandom % 50) == 0;
            seed16  = (($urandom % 4) == 0) ? 16'h0 : 16'($urandom);
            blank16 = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
        end

        cyc(1);
        load8 = 1'b0; freeze8 = 1'b0; step8 = 1'b0;
        blank16 = 4'h0;
        load16 = 1'b1;
        seed16 = 16'hACE1;
        cyc(1);
        load16 = 1'b0;
        cyc(65535);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
